// File: rtl/hier_node_pkg.sv
// rtl/hier_node_pkg.sv - shared state and mode types for the hierarchy dispatch node
package hier_node_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} node_state_e;
  typedef enum logic {MODE_BCAST, MODE_SEQ} node_mode_e;

endpackage

// File: rtl/hier_node_prio_pick.sv
// rtl/hier_node_prio_pick.sv - one-hot lowest-set-bit picker, zero in gives zero out
module hier_node_prio_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    grant_o = req_i & (~req_i + N'(1));
  end

endmodule

// File: rtl/hier_node_dispatch.sv
// rtl/hier_node_dispatch.sv - hierarchy node: fans one request out to child channels, collects one response
module hier_node_dispatch
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_mode,
  input  logic [NUM_CHILDREN-1:0] req_mask,
  output logic [NUM_CHILDREN-1:0] child_start,
  input  logic [NUM_CHILDREN-1:0] child_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [NUM_CHILDREN-1:0] rsp_done_mask,
  output logic                    rsp_timeout,
  output logic [CNT_W-1:0]        rsp_cycles
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  node_state_e             state_q;
  node_mode_e              mode_q;
  logic [NUM_CHILDREN-1:0] mask_q, pending_q, cur_q, done_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TW-1:0]           wait_q;
  logic                    req_ready_q, rsp_valid_q, rsp_timeout_q;
  logic [NUM_CHILDREN-1:0] child_start_q, rsp_done_mask_q;
  logic [CNT_W-1:0]        rsp_cycles_q;

  logic [NUM_CHILDREN-1:0] outstanding, done_nx, pending_nx, pick_in, pick_out;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    cur_done, all_done, timeout_hit;

  hier_node_prio_pick #(.N(NUM_CHILDREN)) u_pick (
    .req_i   (pick_in),
    .grant_o (pick_out)
  );

  // In sequential mode only the child currently running may complete.
  always_comb begin
    outstanding = (mode_q == MODE_SEQ) ? (cur_q & ~done_q) : (mask_q & ~done_q);
    done_nx     = done_q | (child_done & outstanding);
    pending_nx  = pending_q & ~cur_q;
    cur_done    = |(done_nx & cur_q);
    all_done    = (mode_q == MODE_SEQ) ? (cur_done && (pending_nx == '0)) : (done_nx == mask_q);
    pick_in     = (state_q == IDLE) ? req_mask : pending_nx;
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (wait_q == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mode_q          <= MODE_BCAST;
      mask_q          <= '0;
      pending_q       <= '0;
      cur_q           <= '0;
      done_q          <= '0;
      cnt_q           <= '0;
      wait_q          <= '0;
      req_ready_q     <= 1'b0;
      child_start_q   <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_done_mask_q <= '0;
      rsp_timeout_q   <= 1'b0;
      rsp_cycles_q    <= '0;
    end else begin
      child_start_q <= '0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            mode_q      <= node_mode_e'(req_mode);
            mask_q      <= req_mask;
            pending_q   <= req_mask;
            done_q      <= '0;
            cnt_q       <= CNT_W'(1);
            wait_q      <= '0;
            if (req_mask == '0) begin
              state_q         <= RESP;
              rsp_valid_q     <= 1'b1;
              rsp_done_mask_q <= '0;
              rsp_timeout_q   <= 1'b0;
              rsp_cycles_q    <= CNT_W'(1);
            end else begin
              state_q       <= START;
              cur_q         <= req_mode ? pick_out : req_mask;
              child_start_q <= req_mode ? pick_out : req_mask;
            end
          end
        end
        START: begin
          state_q <= WAIT;
          wait_q  <= '0;
          cnt_q   <= cnt_inc;
        end
        WAIT: begin
          cnt_q  <= cnt_inc;
          wait_q <= wait_q + TW'(1);
          done_q <= done_nx;
          if (all_done || timeout_hit) begin
            state_q         <= RESP;
            rsp_valid_q     <= 1'b1;
            rsp_done_mask_q <= done_nx;
            rsp_timeout_q   <= !all_done;
            rsp_cycles_q    <= cnt_inc;
          end else if (mode_q == MODE_SEQ && cur_done) begin
            state_q       <= START;
            pending_q     <= pending_nx;
            cur_q         <= pick_out;
            child_start_q <= pick_out;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign child_start   = child_start_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_done_mask = rsp_done_mask_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_cycles    = rsp_cycles_q;

endmodule

// File: tb/tb_hier_node_dispatch.sv
// tb/tb_hier_node_dispatch.sv - directed self-checking bench for hier_node_dispatch
module tb_hier_node_dispatch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [4:0] req_mask = '0;
  logic [4:0] child_start;
  logic [4:0] child_done = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_done_mask;
  logic       rsp_timeout;
  logic [2:0] rsp_cycles;

  int errors = 0;
  int checks = 0;

  logic [4:0] sched  [0:31];
  logic [4:0] starts [0:31];
  int         rsp_cyc;

  hier_node_dispatch #(.NUM_CHILDREN(5), .CNT_W(3), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mode      (req_mode),
    .req_mask      (req_mask),
    .child_start   (child_start),
    .child_done    (child_done),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_done_mask (rsp_done_mask),
    .rsp_timeout   (rsp_timeout),
    .rsp_cycles    (rsp_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_sched();
    for (int i = 0; i < 32; i++) begin
      sched[i]  = '0;
      starts[i] = '0;
    end
  endtask

  // Accept happens at the edge closing cycle 0; the loop then observes cycles 1..31.
  task automatic run_req(input logic mode, input logic [4:0] mask);
    req_valid = 1'b1;
    req_mode  = mode;
    req_mask  = mask;
    step();
    req_valid = 1'b0;
    rsp_cyc   = -1;
    for (int n = 1; n < 32 && rsp_cyc < 0; n++) begin
      starts[n] = child_start;
      if (rsp_valid) begin
        rsp_cyc = n;
      end else begin
        child_done = sched[n];
        step();
        child_done = '0;
      end
    end
  endtask

  task automatic ack(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, req_ready, 1);
    chk({tag, "_valid_after"}, rsp_valid, 0);
  endtask

  initial begin
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_child_start", child_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_done_mask", rsp_done_mask, 0);
    chk("rst_timeout", rsp_timeout, 0);
    chk("rst_cycles", rsp_cycles, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready_rise", req_ready, 1);

    clr_sched();
    sched[3] = 5'b00001; sched[4] = 5'b00100; sched[6] = 5'b10000;
    run_req(1'b0, 5'b10101);
    chk("bc_start1", starts[1], 5'b10101);
    chk("bc_start2", starts[2], 0);
    chk("bc_rsp_cyc", rsp_cyc, 7);
    chk("bc_done", rsp_done_mask, 5'b10101);
    chk("bc_cycles", rsp_cycles, 7);
    chk("bc_timeout", rsp_timeout, 0);
    ack("bc");

    clr_sched();
    sched[3] = 5'b00010; sched[6] = 5'b01000;
    run_req(1'b1, 5'b01010);
    chk("seq_start1", starts[1], 5'b00010);
    chk("seq_start2", starts[2], 0);
    chk("seq_start4", starts[4], 5'b01000);
    chk("seq_rsp_cyc", rsp_cyc, 7);
    chk("seq_done", rsp_done_mask, 5'b01010);
    chk("seq_cycles", rsp_cycles, 7);
    chk("seq_timeout", rsp_timeout, 0);
    ack("seq");

    clr_sched();
    run_req(1'b0, 5'b00000);
    chk("empty_start1", starts[1], 0);
    chk("empty_rsp_cyc", rsp_cyc, 1);
    chk("empty_done", rsp_done_mask, 0);
    chk("empty_cycles", rsp_cycles, 1);
    ack("empty");

    // Eight WAIT cycles (2..9) then abort; elapsed 10 saturates to 7 in a 3-bit counter.
    clr_sched();
    sched[3] = 5'b00001;
    run_req(1'b0, 5'b00011);
    chk("to_rsp_cyc", rsp_cyc, 10);
    chk("to_timeout", rsp_timeout, 1);
    chk("to_done", rsp_done_mask, 5'b00001);
    chk("to_cycles_sat", rsp_cycles, 7);
    ack("to");

    clr_sched();
    sched[2] = 5'b10001; sched[3] = 5'b00001; sched[5] = 5'b00010;
    run_req(1'b0, 5'b00011);
    chk("spur_rsp_cyc", rsp_cyc, 6);
    chk("spur_done", rsp_done_mask, 5'b00011);
    chk("spur_timeout", rsp_timeout, 0);
    ack("spur");

    // Early done from an unstarted child and a done in the START cycle are both dropped.
    clr_sched();
    sched[2] = 5'b00010; sched[3] = 5'b00001; sched[4] = 5'b00010; sched[6] = 5'b00010;
    run_req(1'b1, 5'b00011);
    chk("seqdrop_start4", starts[4], 5'b00010);
    chk("seqdrop_rsp_cyc", rsp_cyc, 7);
    chk("seqdrop_done", rsp_done_mask, 5'b00011);
    ack("seqdrop");

    clr_sched();
    sched[3] = 5'b00110;
    run_req(1'b0, 5'b00110);
    chk("sim_rsp_cyc", rsp_cyc, 4);
    chk("sim_cycles", rsp_cycles, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_done", rsp_done_mask, 5'b00110);
      chk("hold_cycles", rsp_cycles, 4);
      chk("hold_req_ready", req_ready, 0);
    end
    ack("hold");

    req_valid = 1'b1; req_mode = 1'b0; req_mask = 5'b00011;
    step();
    req_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_start", child_start, 0);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_done", rsp_done_mask, 0);
    chk("arst_cycles", rsp_cycles, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_ready_rise", req_ready, 1);
    clr_sched();
    sched[2] = 5'b00011;
    run_req(1'b0, 5'b00011);
    chk("post_start1", starts[1], 5'b00011);
    chk("post_rsp_cyc", rsp_cyc, 3);
    chk("post_done", rsp_done_mask, 5'b00011);
    chk("post_cycles", rsp_cycles, 3);
    chk("post_timeout", rsp_timeout, 0);
    ack("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
